// File: rtl/clock_divider_pkg.sv
// Shared encodings for the programmable clock divider: external mode field
// and internal FSM state.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        STEP = 2'b01,
        HALT = 2'b10,
        RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

endpackage

// File: rtl/clock_divider_core.sv
// Period counter plus registered clk/tick generation. A new period starts
// whenever the block becomes active or the count reaches the divisor.
module clock_divider_core #(
    parameter int CNT_W = 24
) (
    input  logic             fast_clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic [CNT_W-1:0] div_cur,
    input  logic [CNT_W-1:0] div_nxt,
    output logic             boundary,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             clk,
    output logic             tick
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             active;
    logic [CNT_W-1:0] cnt;

    assign boundary = active && (cnt == div_cur);

    always_comb begin
        cnt_nxt = '0;
        if (run_en && active && (cnt != div_cur))
            cnt_nxt = cnt + ONE;
    end

    // High phase is cnt in [0, H-1] with H = ceil((div+1)/2) = (div>>1)+1,
    // which avoids ever forming the period itself in CNT_W bits.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            clk    <= 1'b0;
            tick   <= 1'b0;
        end else begin
            active <= run_en;
            cnt    <= cnt_nxt;
            clk    <= run_en && (cnt_nxt <= (div_nxt >> 1));
            tick   <= run_en && (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with run/step/halt control and a
// shadowed divisor that only changes at period boundaries.
module clock_divider_prog
    import clock_divider_pkg::*;
#(
    parameter int               CNT_W       = 24,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 24'hFF_FFFF
) (
    input  logic             fast_clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic             clk,
    output logic             tick,
    output logic             step_done,
    output logic [CNT_W-1:0] div_cur,
    output state_t           state
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mode_t            mode_e;
    state_t           state_nxt;
    logic             boundary;
    logic             apply;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_fix;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] div_pend;
    logic             pend_valid;

    assign mode_e  = mode_t'(mode);
    assign div_fix = (div_in == '0) ? ONE : div_in;
    assign apply   = (state == S_HALT) || boundary;

    // A load in the applying cycle bypasses the shadow register.
    always_comb begin
        div_nxt = div_cur;
        if (apply) begin
            if (div_load)
                div_nxt = div_fix;
            else if (pend_valid)
                div_nxt = div_pend;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT: begin
                if (mode_e == RUN)
                    state_nxt = S_RUN;
                else if ((mode_e == STEP) && step_req)
                    state_nxt = S_STEP;
            end
            S_RUN:   if (boundary && (mode_e != RUN)) state_nxt = S_HALT;
            S_STEP:  if (boundary) state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state      <= S_HALT;
            step_done  <= 1'b0;
            div_cur    <= DEFAULT_DIV;
            div_pend   <= '0;
            pend_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_done <= (state_nxt == S_STEP) && (cnt_nxt == div_nxt);
            div_cur   <= div_nxt;
            if (apply) begin
                pend_valid <= 1'b0;
            end else if (div_load) begin
                div_pend   <= div_fix;
                pend_valid <= 1'b1;
            end
        end
    end

    clock_divider_core #(.CNT_W(CNT_W)) u_core (
        .fast_clk (fast_clk),
        .reset    (reset),
        .run_en   (state_nxt != S_HALT),
        .div_cur  (div_cur),
        .div_nxt  (div_nxt),
        .boundary (boundary),
        .cnt_nxt  (cnt_nxt),
        .clk      (clk),
        .tick     (tick)
    );

endmodule

// File: tb/tb_clock_divider_prog.sv
// Randomised scoreboard bench for clock_divider_prog with CNT_W = 4,
// DEFAULT_DIV = 15; a period-level model predicts every output cycle.
module tb_clock_divider_prog;
  import clock_divider_pkg::*;

  logic       fast_clk = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] div_in   = '0;
  logic       div_load = 1'b0;
  logic [1:0] mode     = HALT;
  logic       step_req = 1'b0;
  logic       clk, tick, step_done;
  logic [3:0] div_cur;
  state_t     dut_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  // model: state 0 halt / 1 run / 2 step, phase within period, period length
  int m_st, m_ph, m_per, m_cur, m_pend;
  bit m_pv, m_clk, m_tick, m_sd;

  clock_divider_prog #(.CNT_W(4), .DEFAULT_DIV(4'd15)) dut (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .div_in    (div_in),
    .div_load  (div_load),
    .mode      (mode),
    .step_req  (step_req),
    .clk       (clk),
    .tick      (tick),
    .step_done (step_done),
    .div_cur   (div_cur),
    .state     (dut_state)
  );

  always #5 fast_clk = ~fast_clk;

  function automatic void model_reset();
    m_st = 0; m_ph = 0; m_per = 16; m_cur = 15; m_pend = 0; m_pv = 0;
    m_clk = 0; m_tick = 0; m_sd = 0;
  endfunction

  function automatic void model_step(input logic [1:0] md, input bit sr, input bit ld, input int din);
    int  fixd;
    int  nst;
    bit  bnd;
    bit  app;
    fixd = (din == 0) ? 1 : din;
    bnd  = (m_st != 0) && (m_ph == m_per - 1);
    app  = (m_st == 0) || bnd;
    if (m_st == 0) nst = (md == RUN) ? 1 : ((md == STEP) && sr) ? 2 : 0;
    else if (!bnd) nst = m_st;
    else nst = ((m_st == 1) && (md == RUN)) ? 1 : 0;
    if (app) begin
      if (ld) m_cur = fixd;
      else if (m_pv) m_cur = m_pend;
      m_pv = 0;
    end else if (ld) begin
      m_pend = fixd;
      m_pv   = 1;
    end
    if (nst == 0) m_ph = 0;
    else if ((m_st == 0) || bnd) begin
      m_ph  = 0;
      m_per = m_cur + 1;
    end else m_ph = m_ph + 1;
    m_st   = nst;
    m_clk  = (nst != 0) && (m_ph < m_per - m_per / 2);
    m_tick = (nst != 0) && (m_ph == 0);
    m_sd   = (nst == 2) && (m_ph == m_per - 1);
  endfunction

  task automatic drive(input logic [1:0] md, input bit ld, input int din, input bit sr);
    mode = md; div_load = ld; div_in = 4'(din); step_req = sr;
  endtask

  // Advance one cycle: model the edge just taken, then push the expected outputs.
  task automatic step_cyc(input bit rst_now);
    @(posedge fast_clk);
    #1;
    if (reset) model_reset();
    else model_step(mode, step_req, div_load, int'(div_in));
    if (rst_now) begin
      reset = 1'b1;
      model_reset();
    end else reset = 1'b0;
    exp_q.push_back({m_clk, m_tick, m_sd, 4'(m_cur)});
  endtask

  task automatic run(input int n, input logic [1:0] md, input int ldp, input int sp, input int rstp);
    for (int i = 0; i < n; i++) begin
      drive(md, $urandom_range(0, 99) < ldp, $urandom_range(0, 15), $urandom_range(0, 99) < sp);
      step_cyc($urandom_range(0, 999) < rstp);
    end
  endtask

  // Run in RUN mode until the model sits at the given phase (-1 = boundary).
  task automatic wait_ph(input int ph);
    int k;
    for (k = 0; k < 80; k++) begin
      if ((m_st != 0) && (m_ph == ((ph < 0) ? m_per - 1 : ph))) break;
      drive(RUN, 0, 0, 0);
      step_cyc(0);
    end
    n_tests++;
    if (k >= 80) begin
      n_fail++;
      $display("FAIL wait_phase actual=timeout required=phase %0d", ph);
    end
  endtask

  initial begin : monitor
    logic [6:0] e;
    logic [6:0] a;
    forever begin
      @(negedge fast_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {clk, tick, step_done, div_cur};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t {clk,tick,step_done,div_cur} actual=%b_%b_%b_%h required=%b_%b_%b_%h",
                   $time, a[6], a[5], a[4], a[3:0], e[6], e[5], e[4], e[3:0]);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    drive(HALT, 0, 0, 0);
    step_cyc(1);
    step_cyc(0);
    // steady run at the default period of 16
    run(40, RUN, 0, 0, 0);
    // mid-period load of 4, then 0, then a load exactly on a boundary
    wait_ph(5);
    drive(RUN, 1, 4, 0); step_cyc(0);
    run(30, RUN, 0, 0, 0);
    drive(RUN, 1, 0, 0); step_cyc(0);
    run(20, RUN, 0, 0, 0);
    wait_ph(-1);
    drive(RUN, 1, 2, 0); step_cyc(0);
    run(20, RUN, 0, 0, 0);
    // single steps with P = 5, a stray mid-step request, then held requests
    run(20, HALT, 0, 0, 0);
    drive(HALT, 1, 4, 0); step_cyc(0);
    run(3, HALT, 0, 0, 0);
    drive(STEP, 0, 0, 1); step_cyc(0);
    drive(STEP, 0, 0, 0); step_cyc(0);
    drive(STEP, 0, 0, 1); step_cyc(0);
    run(10, STEP, 0, 0, 0);
    run(15, STEP, 0, 100, 0);
    // leave RUN three cycles into a P = 16 period
    run(5, HALT, 0, 0, 0);
    drive(HALT, 1, 15, 0); step_cyc(0);
    wait_ph(3);
    run(25, HALT, 0, 0, 0);
    // reset while a divisor is pending
    wait_ph(4);
    drive(RUN, 1, 7, 0); step_cyc(0);
    drive(RUN, 0, 0, 0); step_cyc(1);
    drive(RUN, 0, 0, 0); step_cyc(0);
    run(40, RUN, 0, 0, 0);
    // randomised mix of everything
    for (int blk = 0; blk < 60; blk++)
      run($urandom_range(10, 60), 2'($urandom_range(0, 3)), 6, 30, 3);
    drive(HALT, 0, 0, 0);
    step_cyc(0);
    repeat (3) @(negedge fast_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
